// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the multi-cycle data-memory responder: access sizes,
// FSM states and the alignment/legality check used by the lane aligner.
package mem_resp_pkg;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Illegal size, or an address that does not sit on the access's natural boundary.
    function automatic logic access_err(input logic [1:0] addr_lo, input logic [1:0] maskmode);
        logic err;
        err = 1'b0;
        case (maskmode)
            MASK_BYTE: err = 1'b0;
            MASK_HALF: err = addr_lo[0];
            MASK_WORD: err = |addr_lo;
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request and response channels between the load/store unit (master) and the responder (slave).
// Both channels use valid/ready; nothing transfers unless both are high on a clock edge.
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [1:0]            req_maskmode;
    logic                  req_uns;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_maskmode, req_uns, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_maskmode, req_uns, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Purely combinational lane logic: merges store data into the old word and formats load data.
// No state, no handshake; the caller decides when the results are used.
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  maskmode,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data,
    output logic        err
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = old_word[{addr_lo, 3'b000} +: 8];
        rd_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    end

    always_comb begin
        err     = access_err(addr_lo, maskmode);
        wr_word = old_word;
        rd_data = '0;
        case (maskmode)
            MASK_BYTE: begin
                wr_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                rd_data = uns ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            MASK_HALF: begin
                wr_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                rd_data = uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            MASK_WORD: begin
                wr_word = wdata;
                rd_data = old_word;
            end
            default: begin
                wr_word = old_word;
                rd_data = '0;
            end
        endcase
        // A faulting access must neither change memory nor leak data.
        if (err) begin
            wr_word = old_word;
            rd_data = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target: one request in flight, access after LATENCY cycles.
// Latency: rsp_valid rises LATENCY cycles after accept; response held until rsp_ready.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256,
    parameter int LATENCY    = 2
) (
    input  logic clk,
    input  logic rstn,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            maskmode_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  access;
    logic                  rsp_done;

    logic                  sel_write;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [1:0]            sel_maskmode;
    logic                  sel_uns;

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  lane_err;
    logic                  mem_we;
    logic                  unused_addr_hi;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        access   = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        access  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    access  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the accept edge, so the live request feeds the lanes.
    always_comb begin
        if (state_q == S_IDLE) begin
            sel_write    = bus.req_write;
            sel_addr     = bus.req_addr;
            sel_wdata    = bus.req_wdata;
            sel_maskmode = bus.req_maskmode;
            sel_uns      = bus.req_uns;
        end else begin
            sel_write    = write_q;
            sel_addr     = addr_q;
            sel_wdata    = wdata_q;
            sel_maskmode = maskmode_q;
            sel_uns      = uns_q;
        end
    end

    assign idx            = sel_addr[IDX_W+1:2];
    assign old_word       = mem[idx];
    assign unused_addr_hi = ^sel_addr[DATA_WIDTH-1:IDX_W+2];

    mem_lane_align u_lane_align (
        .addr_lo  (sel_addr[1:0]),
        .maskmode (sel_maskmode),
        .uns      (sel_uns),
        .wdata    (sel_wdata),
        .old_word (old_word),
        .wr_word  (wr_word),
        .rd_data  (rd_data),
        .err      (lane_err)
    );

    // Gating with rstn keeps a store from landing while reset is asserted.
    assign mem_we = access && sel_write && !lane_err && rstn;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            maskmode_q <= MASK_WORD;
            uns_q      <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q    <= bus.req_write;
                addr_q     <= bus.req_addr;
                wdata_q    <= bus.req_wdata;
                maskmode_q <= bus.req_maskmode;
                uns_q      <= bus.req_uns;
            end
            if (access) begin
                rdata_q <= (sel_write || lane_err) ? '0 : rd_data;
                err_q   <= lane_err;
            end else if (rsp_done) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expectations queued at accept, checked at response.
module tb_data_mem_responder;
    import mem_resp_pkg::*;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] d;
        logic        e;
        string       name;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    data_mem_responder_if #(.DATA_WIDTH(32)) bus ();

    data_mem_responder #(
        .DATA_WIDTH (32),
        .MEM_WORDS  (256),
        .LATENCY    (LAT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, check accept-to-response latency, optional back-pressure, and the payload.
    task automatic transact(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] mode, input logic uns, input logic [31:0] exp_d,
                            input logic exp_e, input int hold, input string name);
        exp_t e;
        exp_t got;
        int   n;
        logic [31:0] first_d;
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_maskmode = mode;
        bus.req_uns      = uns;
        bus.rsp_ready    = (hold == 0);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL %s accept timeout: req_ready=%0b required 1", name, bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.d = exp_d; e.e = exp_e; e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'h0BAD_F00D;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles required %0d", name, n, LAT);
        end
        if (!bus.rsp_valid) begin
            void'(sb_q.pop_front());
            return;
        end
        first_d = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== first_d || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%0b rdata=%08h req_ready=%0b required 1 %08h 0",
                         name, i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, first_d);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        got = sb_q.pop_front();
        checks++;
        if (bus.rsp_rdata !== got.d || bus.rsp_err !== got.e) begin
            errors++;
            $display("FAIL %s data: rdata=%08h err=%0b required %08h %0b",
                     got.name, bus.rsp_rdata, bus.rsp_err, got.d, got.e);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post-handshake: valid=%0b rdata=%08h err=%0b req_ready=%0b required 0 0 0 1",
                     name, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_hold%0d: req_ready=%0b rsp_valid=%0b rdata=%08h required 1 0 0",
                         i, bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
            end
        end
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle%0d: req_ready=%0b rsp_valid=%0b rdata=%08h required 1 0 0",
                         i, bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
            end
        end
    endtask

    task automatic test_word_rw();
        transact(1'b1, 32'h10, 32'hDEADBEEF, MASK_WORD, 1'b0, 32'h0, 1'b0, 0, "sw_10");
        transact(1'b0, 32'h10, 32'h0, MASK_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 0, "lw_10");
        transact(1'b0, 32'h10, 32'h0, MASK_WORD, 1'b1, 32'hDEADBEEF, 1'b0, 0, "lw_uns_10");
    endtask

    task automatic test_subword_load();
        transact(1'b0, 32'h11, 32'h0, MASK_BYTE, 1'b0, 32'hFFFFFFBE, 1'b0, 0, "lb_11");
        transact(1'b0, 32'h11, 32'h0, MASK_BYTE, 1'b1, 32'h000000BE, 1'b0, 0, "lbu_11");
        transact(1'b0, 32'h12, 32'h0, MASK_HALF, 1'b0, 32'hFFFFDEAD, 1'b0, 0, "lh_12");
        transact(1'b0, 32'h12, 32'h0, MASK_HALF, 1'b1, 32'h0000DEAD, 1'b0, 0, "lhu_12");
        transact(1'b0, 32'h10, 32'h0, MASK_BYTE, 1'b0, 32'hFFFFFFEF, 1'b0, 0, "lb_10");
    endtask

    task automatic test_subword_store();
        transact(1'b1, 32'h13, 32'hFFFFFF55, MASK_BYTE, 1'b0, 32'h0, 1'b0, 0, "sb_13");
        transact(1'b0, 32'h10, 32'h0, MASK_WORD, 1'b0, 32'h55ADBEEF, 1'b0, 0, "lw_after_sb");
        transact(1'b1, 32'h10, 32'hCAFE1234, MASK_HALF, 1'b0, 32'h0, 1'b0, 0, "sh_10");
        transact(1'b0, 32'h10, 32'h0, MASK_WORD, 1'b0, 32'h55AD1234, 1'b0, 0, "lw_after_sh");
    endtask

    task automatic test_errors();
        transact(1'b0, 32'h12, 32'h0, MASK_WORD, 1'b0, 32'h0, 1'b1, 0, "lw_12_misaligned");
        transact(1'b1, 32'h11, 32'hFFFF9999, MASK_HALF, 1'b0, 32'h0, 1'b1, 0, "sh_11_misaligned");
        transact(1'b0, 32'h10, 32'h0, MASK_WORD, 1'b0, 32'h55AD1234, 1'b0, 0, "lw_after_bad_sh");
        transact(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 0, "load_mode11");
        transact(1'b1, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 0, "store_mode11");
        transact(1'b0, 32'h10, 32'h0, MASK_WORD, 1'b0, 32'h55AD1234, 1'b0, 0, "lw_after_bad_st");
    endtask

    task automatic test_backpressure();
        transact(1'b0, 32'h10, 32'h0, MASK_WORD, 1'b0, 32'h55AD1234, 1'b0, 5, "lw_backpressure");
        transact(1'b0, 32'h12, 32'h0, MASK_HALF, 1'b1, 32'h000055AD, 1'b0, 3, "lhu_backpressure");
    endtask

    task automatic test_mid_reset();
        transact(1'b1, 32'h20, 32'h11111111, MASK_WORD, 1'b0, 32'h0, 1'b0, 0, "sw_20_old");
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_addr     = 32'h20;
        bus.req_wdata    = 32'hAAAAAAAA;
        bus.req_maskmode = MASK_WORD;
        bus.req_uns      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_wait: req_ready=%0b required 0", bus.req_ready);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: req_ready=%0b rsp_valid=%0b required 1 0",
                     bus.req_ready, bus.rsp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        transact(1'b0, 32'h20, 32'h0, MASK_WORD, 1'b0, 32'h11111111, 1'b0, 0, "lw_20_after_reset");
    endtask

    task automatic test_alias();
        transact(1'b0, 32'h410, 32'h0, MASK_WORD, 1'b0, 32'h55AD1234, 1'b0, 0, "lw_410_alias");
        transact(1'b1, 32'h8000_0413, 32'h00000077, MASK_BYTE, 1'b0, 32'h0, 1'b0, 0, "sb_alias_413");
        transact(1'b0, 32'h10, 32'h0, MASK_WORD, 1'b0, 32'h77AD1234, 1'b0, 0, "lw_after_alias_sb");
    endtask

    task automatic test_back_to_back();
        transact(1'b1, 32'h3FC, 32'h01020304, MASK_WORD, 1'b0, 32'h0, 1'b0, 0, "sw_top");
        transact(1'b0, 32'h3FF, 32'h0, MASK_BYTE, 1'b1, 32'h00000001, 1'b0, 0, "lbu_top");
        transact(1'b0, 32'h3FC, 32'h0, MASK_HALF, 1'b0, 32'h00000304, 1'b0, 0, "lh_top");
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rstn             = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_maskmode = MASK_WORD;
        bus.req_uns      = 1'b0;
        bus.rsp_ready    = 1'b1;

        test_reset();
        test_word_rw();
        test_subword_load();
        test_subword_store();
        test_errors();
        test_backpressure();
        test_mid_reset();
        test_alias();
        test_back_to_back();

        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
